// File: rtl/mhvpis_pkg.sv
// Shared types and helpers for the mhvpis_nch interrupt unit.
package mhvpis_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      ACKW = 2'd2
   } mhvpis_st_e;

   // Ceiling log2, never less than 1 so every derived field has at least one bit.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 1;
      while ((32'd1 << r) < n) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/mhvpis_nch_if.sv
// Stage0-facing handshake bundle of the interrupt unit.
interface mhvpis_nch_if
   import mhvpis_pkg::*;
#(
   parameter int unsigned N_CH       = 4,
   parameter int unsigned PC_W       = 8,
   parameter int unsigned NEST_DEPTH = 4
);
   localparam int unsigned ID_W = clog2(N_CH);
   localparam int unsigned NL_W = clog2(NEST_DEPTH + 1);

   logic            itr_en;
   logic            itr_ack;
   logic            itr_ret;
   logic            i_pending;
   logic [PC_W-1:0] pc_out;
   logic [ID_W-1:0] itr_id;
   logic [NL_W-1:0] nest_lvl;
   logic            ret_err;

   // Interrupt unit side
   modport master (
      input  itr_en, itr_ack, itr_ret,
      output i_pending, pc_out, itr_id, nest_lvl, ret_err
   );

   // Stage0 controller side
   modport slave (
      output itr_en, itr_ack, itr_ret,
      input  i_pending, pc_out, itr_id, nest_lvl, ret_err
   );
endinterface

// File: rtl/prio_enc_n.sv
// Highest-index-wins priority encoder.
module prio_enc_n
   import mhvpis_pkg::*;
#(
   parameter int unsigned N = 4,
   parameter int unsigned W = clog2(N)
) (
   input  logic [N-1:0] req_i,
   output logic [W-1:0] idx_c_o,
   output logic         vld_c_o
);

   // Later (higher) set bits overwrite earlier ones.
   always_comb begin
      idx_c_o = '0;
      vld_c_o = 1'b0;
      for (int i = 0; i < int'(N); i++) begin
         if (req_i[i]) begin
            idx_c_o = W'(i);
            vld_c_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mhvpis_nch.sv
// N-channel maskable, vectored, nested-priority interrupt unit.
// Optional: define MHVPIS_EDGE_EN to add per-channel rising-edge qualification (edge_sel port).
module mhvpis_nch
   import mhvpis_pkg::*;
#(
   parameter int unsigned    N_CH       = 4,
   parameter int unsigned    PC_W       = 8,
   parameter int unsigned    VEC_BASE   = 32'hF0,
   parameter int unsigned    VEC_STRIDE = 4,
   parameter int unsigned    NEST_DEPTH = 4,
   parameter logic [N_CH-1:0] MASK_RST  = '0
) (
   input  logic            g_clk,
   input  logic            g_clr,
   input  logic [N_CH-1:0] itr_in,
   input  logic [N_CH-1:0] mask_in,
   input  logic            mask_ld,
`ifdef MHVPIS_EDGE_EN
   input  logic [N_CH-1:0] edge_sel,
`endif
   mhvpis_nch_if.master    bus
);

   localparam int unsigned ID_W = clog2(N_CH);
   localparam int unsigned NL_W = clog2(NEST_DEPTH + 1);
   localparam int unsigned SP_W = clog2(NEST_DEPTH);

   mhvpis_st_e      state_q, state_d;
   logic [N_CH-1:0] pend_q, pend_d, mask_q, qual_c, clr_c;
   logic [ID_W-1:0] id_q, id_d, cand_c;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            cand_v_c, win_c, push_c, pop_c;
   logic            ipend_q, err_q;
   logic [NL_W-1:0] nest_q;
   logic [SP_W-1:0] top_ptr_c, new_ptr_c;
   logic [ID_W-1:0] stk_q [NEST_DEPTH];

`ifdef MHVPIS_EDGE_EN
   logic [N_CH-1:0] prev_q;

   // Previous line level for rising-edge detection.
   always_ff @(posedge g_clk or negedge g_clr) begin
      if (!g_clr) prev_q <= '0;
      else        prev_q <= itr_in;
   end

   assign qual_c = itr_in & ~(edge_sel & prev_q);
`else
   assign qual_c = itr_in;
`endif

   prio_enc_n #(.N(N_CH), .W(ID_W)) u_cand (
      .req_i   (pend_q & mask_q),
      .idx_c_o (cand_c),
      .vld_c_o (cand_v_c)
   );

   assign top_ptr_c = SP_W'(nest_q - NL_W'(1));
   assign new_ptr_c = SP_W'(nest_q);
   assign pop_c     = bus.itr_ret && (nest_q != '0);
   // Candidate must strictly outrank the routine currently running (none when the stack is empty).
   assign win_c     = cand_v_c && ((nest_q == '0) || (cand_c > stk_q[top_ptr_c]));
   assign clr_c     = push_c ? (N_CH'(1) << id_q) : '0;
   assign pend_d    = (pend_q & ~clr_c) | qual_c;

   // FSM state register.
   always_ff @(posedge g_clk or negedge g_clr) begin
      if (!g_clr) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state, vector latch and push decision.
   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      pc_d    = pc_q;
      push_c  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.itr_en && win_c && (nest_q < NL_W'(NEST_DEPTH))) begin
               state_d = REQ;
               id_d    = cand_c;
               pc_d    = PC_W'(VEC_BASE + 32'(cand_c) * VEC_STRIDE);
            end
         end
         REQ: begin
            if (bus.itr_ack) begin
               push_c  = 1'b1;
               state_d = ACKW;
            end else if (!bus.itr_en) begin
               state_d = IDLE;
            end
         end
         ACKW: begin
            if (!bus.itr_ack) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Pending, mask and registered outputs.
   always_ff @(posedge g_clk or negedge g_clr) begin
      if (!g_clr) begin
         pend_q  <= '0;
         mask_q  <= MASK_RST;
         id_q    <= '0;
         pc_q    <= '0;
         ipend_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         pend_q  <= pend_d;
         if (mask_ld) mask_q <= mask_in;
         id_q    <= id_d;
         pc_q    <= pc_d;
         ipend_q <= (state_d == REQ);
         err_q   <= bus.itr_ret && (nest_q == '0);
      end
   end

   // Priority stack; a simultaneous pop and push replaces the top entry.
   always_ff @(posedge g_clk or negedge g_clr) begin
      if (!g_clr) begin
         nest_q <= '0;
         for (int i = 0; i < int'(NEST_DEPTH); i++) stk_q[i] <= '0;
      end else begin
         if (push_c) begin
            if (pop_c) stk_q[top_ptr_c] <= id_q;
            else       stk_q[new_ptr_c] <= id_q;
         end
         if (push_c && !pop_c)      nest_q <= nest_q + NL_W'(1);
         else if (pop_c && !push_c) nest_q <= nest_q - NL_W'(1);
      end
   end

   assign bus.i_pending = ipend_q;
   assign bus.pc_out    = pc_q;
   assign bus.itr_id    = id_q;
   assign bus.nest_lvl  = nest_q;
   assign bus.ret_err   = err_q;

endmodule

// File: tb/tb_mhvpis_nch.sv
// Directed bench for mhvpis_nch with a behavioural reference model.
module tb_mhvpis_nch;

   logic       g_clk = 1'b0;
   logic       g_clr = 1'b0;
   logic [3:0] itr_in = '0;
   logic [3:0] mask_in = '0;
   logic       mask_ld = 1'b0;
`ifdef MHVPIS_EDGE_EN
   logic [3:0] edge_sel = '0;
`endif

   int vectors = 0;
   int miscompares = 0;

   mhvpis_nch_if #(.N_CH(4), .PC_W(8), .NEST_DEPTH(4)) bus ();

   mhvpis_nch dut (
      .g_clk   (g_clk),
      .g_clr   (g_clr),
      .itr_in  (itr_in),
      .mask_in (mask_in),
      .mask_ld (mask_ld),
`ifdef MHVPIS_EDGE_EN
      .edge_sel(edge_sel),
`endif
      .bus     (bus)
   );

   always #5 g_clk = ~g_clk;

   task automatic cmp(input string nm, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0d (0x%0h), expected %0d (0x%0h)", nm, $time, act, act, exp, exp);
      end
   endtask

   // Reference model: phase 0 idle, 1 requesting, 2 waiting for ack release.
   int         m_ph = 0;
   logic [3:0] m_pend = '0;
   logic [3:0] m_mask = '0;
   logic [3:0] m_prev = '0;
   int         m_stk[$];
   int         m_id = 0;
   int         m_pc = 0;
   bit         m_err = 1'b0;

   always @(posedge g_clk or negedge g_clr) begin
      int cand, run;
      bit push;
      logic [3:0] q;
      if (!g_clr) begin
         m_ph = 0; m_pend = '0; m_mask = '0; m_prev = '0;
         m_stk.delete(); m_id = 0; m_pc = 0; m_err = 1'b0;
      end else begin
         push  = (m_ph == 1) && bus.itr_ack;
         m_err = bus.itr_ret && (m_stk.size() == 0);
         cand  = -1;
         for (int i = 0; i < 4; i++) if (m_pend[i] && m_mask[i]) cand = i;
         run   = (m_stk.size() > 0) ? m_stk[$] : -1;
         q     = itr_in;
`ifdef MHVPIS_EDGE_EN
         q      = itr_in & ~(edge_sel & m_prev);
         m_prev = itr_in;
`endif
         case (m_ph)
            0: if (bus.itr_en && cand > run && m_stk.size() < 4) begin
                  m_ph = 1; m_id = cand; m_pc = (240 + cand * 4) % 256;
               end
            1: if (bus.itr_ack) m_ph = 2; else if (!bus.itr_en) m_ph = 0;
            default: if (!bus.itr_ack) m_ph = 0;
         endcase
         if (bus.itr_ret && m_stk.size() > 0) void'(m_stk.pop_back());
         if (push) begin
            m_stk.push_back(m_id);
            m_pend[m_id] = 1'b0;
         end
         m_pend = m_pend | q;
         if (mask_ld) m_mask = mask_in;
      end
   end

   // Every-cycle comparison against the model while out of reset.
   always @(negedge g_clk) begin
      if (g_clr) begin
         cmp("i_pending", int'(bus.i_pending), (m_ph == 1) ? 1 : 0);
         cmp("pc_out",    int'(bus.pc_out),    m_pc);
         cmp("itr_id",    int'(bus.itr_id),    m_id);
         cmp("nest_lvl",  int'(bus.nest_lvl),  m_stk.size());
         cmp("ret_err",   int'(bus.ret_err),   int'(m_err));
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(negedge g_clk);
         #1;
      end
   endtask

   task automatic pulse(input logic [3:0] v);
      itr_in = v; step(); itr_in = '0; step();
   endtask

   task automatic ack_cycle();
      bus.itr_ack = 1'b1; step(); bus.itr_ack = 1'b0; step();
   endtask

   task automatic ret();
      bus.itr_ret = 1'b1; step(); bus.itr_ret = 1'b0;
   endtask

   task automatic load_mask(input logic [3:0] m);
      mask_in = m; mask_ld = 1'b1; step(); mask_ld = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      bus.itr_en = 1'b1; bus.itr_ack = 1'b0; bus.itr_ret = 1'b0;
      #12;
      cmp("rst_i_pending", int'(bus.i_pending), 0);
      cmp("rst_pc_out",    int'(bus.pc_out),    0);
      cmp("rst_itr_id",    int'(bus.itr_id),    0);
      cmp("rst_nest_lvl",  int'(bus.nest_lvl),  0);
      cmp("rst_ret_err",   int'(bus.ret_err),   0);
      step(); g_clr = 1'b1; step();
      load_mask(4'hF);

      // Single request on ch1, two-edge latency.
      itr_in = 4'b0010; step();
      cmp("t1_not_yet", int'(bus.i_pending), 0);
      itr_in = '0; step();
      cmp("t1_req", int'(bus.i_pending), 1);
      cmp("t1_pc",  int'(bus.pc_out), 8'hF4);
      cmp("t1_id",  int'(bus.itr_id), 1);
      ack_cycle();
      cmp("t1_nest", int'(bus.nest_lvl), 1);
      ret();
      cmp("t1_nest0", int'(bus.nest_lvl), 0);

      // Simultaneous ch0 and ch3: ch3 first, ch0 after return.
      pulse(4'b1001);
      cmp("t2_pc3", int'(bus.pc_out), 8'hFC);
      ack_cycle(); step();
      cmp("t2_blocked", int'(bus.i_pending), 0);
      ret(); step();
      cmp("t2_pc0", int'(bus.pc_out), 8'hF0);
      cmp("t2_req0", int'(bus.i_pending), 1);
      ack_cycle(); ret();

      // Preemption of ch1 by ch2; ch0 waits for both returns.
      pulse(4'b0010); ack_cycle();
      pulse(4'b0101);
      cmp("t3_pc2", int'(bus.pc_out), 8'hF8);
      ack_cycle();
      cmp("t3_nest2", int'(bus.nest_lvl), 2);
      ret(); step();
      cmp("t3_hold", int'(bus.i_pending), 0);
      ret(); step();
      cmp("t3_pc0", int'(bus.pc_out), 8'hF0);
      ack_cycle(); ret();

      // Masked ch1 stays pending, fires when unmasked.
      load_mask(4'b1101);
      pulse(4'b0010); step();
      cmp("t4_masked", int'(bus.i_pending), 0);
      load_mask(4'hF); step();
      cmp("t4_unmasked", int'(bus.i_pending), 1);
      cmp("t4_pc", int'(bus.pc_out), 8'hF4);
      ack_cycle(); ret();

      // Fill the stack, full-stack hold, drain, empty return error.
      for (int ch = 0; ch < 4; ch++) begin
         pulse(4'(1 << ch));
         cmp("t5_fill_id", int'(bus.itr_id), ch);
         ack_cycle();
      end
      cmp("t5_full", int'(bus.nest_lvl), 4);
      pulse(4'b1000); step();
      cmp("t5_no_req", int'(bus.i_pending), 0);
      ret(); step();
      cmp("t5_req3", int'(bus.itr_id), 3);
      ack_cycle();
      for (int k = 0; k < 4; k++) ret();
      cmp("t5_empty", int'(bus.nest_lvl), 0);
      bus.itr_ret = 1'b1; step();
      cmp("t5_err", int'(bus.ret_err), 1);
      bus.itr_ret = 1'b0; step();
      cmp("t5_err_end", int'(bus.ret_err), 0);

      // itr_en withdrawn before ack, request returns when re-enabled.
      pulse(4'b0001);
      cmp("t7_req", int'(bus.i_pending), 1);
      bus.itr_en = 1'b0; step();
      cmp("t7_drop", int'(bus.i_pending), 0);
      bus.itr_en = 1'b1; step();
      cmp("t7_again", int'(bus.i_pending), 1);
      ack_cycle(); ret();

      // Asynchronous reset mid-request.
      pulse(4'b0010); ack_cycle();
      pulse(4'b0100);
      cmp("t6_req", int'(bus.i_pending), 1);
      g_clr = 1'b0; #1;
      cmp("t6_i_pending", int'(bus.i_pending), 0);
      cmp("t6_nest",      int'(bus.nest_lvl),  0);
      cmp("t6_pc",        int'(bus.pc_out),    0);
      step(); g_clr = 1'b1; step();
      load_mask(4'hF);

`ifdef MHVPIS_EDGE_EN
      // Held edge-mode line is serviced exactly once.
      edge_sel = 4'b0100; itr_in = 4'b0100; step(2);
      cmp("te_req", int'(bus.itr_id), 2);
      ack_cycle(); ret(); step(4);
      cmp("te_once", int'(bus.i_pending), 0);
      itr_in = '0; step();
`endif

      step(2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mhvpis_nch.md
Name: mhvpis_nch

Overview:
Parametrised successor to the 4-input MHVPIS interrupt unit. It provides N maskable, vectored, priority interrupt channels and supports nested preemption through an internal priority stack. It uses a 4-phase request/acknowledge handshake with the stage0 controller and a return strobe to unwind nesting. It sits beside stage0 and feeds the MUX_PC vector input and the i_pending flag.

Parameters:
N_CH, 4, number of interrupt channels (2..16); channel N_CH-1 has highest priority
PC_W, 8, width of the program-counter vector output
VEC_BASE, 8'hF0, address of the channel-0 service routine
VEC_STRIDE, 4, address spacing between consecutive channel vectors
NEST_DEPTH, 4, maximum number of nested active interrupts (1..8)
MASK_RST, all zeros, mask register value after reset (1 = channel enabled)

Ports:
g_clk  in  1  global clock, rising edge
g_clr  in  1  global reset, asynchronous, active-low
itr_in  in  N_CH  raw interrupt request lines
mask_in  in  N_CH  new mask value
mask_ld  in  1  loads mask_in into the mask register on this edge
itr_en  in  1  global interrupt enable from stage0
itr_ack  in  1  stage0 has taken the vector (4-phase, level)
itr_ret  in  1  one-cycle return-from-interrupt strobe
edge_sel  in  N_CH  per-channel edge mode (only with MHVPIS_EDGE_EN)
i_pending  out  1  request to stage0
pc_out  out  PC_W  vector address of the requested channel
itr_id  out  clog2(N_CH)  index of the requested channel
nest_lvl  out  clog2(NEST_DEPTH+1)  current nesting depth
ret_err  out  1  registered one-cycle pulse: itr_ret received with the stack empty

Behaviour:
- Reset (g_clr=0, asynchronous): FSM=IDLE; pending, stack and nest_lvl are 0; mask=MASK_RST; i_pending=0, pc_out=0, itr_id=0, ret_err=0. Reset asserted mid-handshake abandons the request; nothing is pushed.
- Pending latch: pending[i] is set on every edge where the request qualifies. Level mode qualifies on itr_in[i]=1. Pending[i] is cleared only when channel i is acknowledged. If set and clear coincide, set wins.
- Masking applies at arbitration only. Masked requests stay pending and fire once unmasked.
- Candidate: highest-index i with pending[i] & mask[i].
- Running priority: top-of-stack channel when nest_lvl>0, otherwise -1.
- FSM states:
  - IDLE: if itr_en, a candidate exists, candidate priority > running priority, and nest_lvl<NEST_DEPTH → REQ. On this transition, latch itr_id=candidate and pc_out=VEC_BASE+candidate*VEC_STRIDE (truncated to PC_W, wraps mod 2^PC_W).
  - REQ: i_pending=1, with itr_id and pc_out frozen. On itr_ack=1: push itr_id, increment nest_lvl, clear pending[itr_id] → ACKW. If itr_en falls before ack → IDLE, no push.
  - ACKW: i_pending=0; wait for itr_ack=0 → IDLE.
- Latency: itr_in rises before edge k → pending set at k → REQ at k+1 → i_pending visible after edge k+1.
- itr_ret: pops the top entry and decrements nest_lvl, in any state.
  - With an empty stack: ignored and ret_err pulses.
  - itr_ret in the same cycle as the push edge: pop first, then push (top replaced, nest_lvl unchanged).
- When the stack is full, new requests stay pending and are not requested until a return.
- mask_ld while in REQ updates the mask register but does not retract the current request.

Optional Feature:
MHVPIS_EDGE_EN.
- Defined: the edge_sel port exists. A channel with edge_sel[i]=1 qualifies only on a rising edge of itr_in[i], using a registered previous value that resets to 0. A held-high line therefore produces a single pending event.
- Undefined: the edge_sel port and the edge registers are absent, and all channels are level-sensitive.

Decomposition:
- Package mhvpis_pkg: FSM state encodings (IDLE=2'd0, REQ=2'd1, ACKW=2'd2) and a clog2 constant function.
- Sub-module prio_enc_n: parametrised N-input highest-index priority encoder producing index and valid. It is used for candidate selection.

Test Plan:
- N_CH=4, mask=4'hF, itr_en=1, pulse itr_in[1] → i_pending high 2 edges later; pc_out=8'hF4, itr_id=1. Ack → nest_lvl=1.
- Channels 0 and 3 asserted in the same cycle → vector 8'hFC (ch3) is served first. After itr_ret and ack-low, ch0 is served at 8'hF0.
- Ch1 is active (nest_lvl=1) and itr_in[2] rises → preemption at 8'hF8, nest_lvl=2. itr_in[0] during the same period → no request until both return strobes.
- mask=4'b1101, itr_in[1] pulsed → no i_pending. Load mask=4'hF → request for ch1 appears.
- Fill NEST_DEPTH=4 with ascending channels 0..3, then retrigger → no request. itr_ret with nest_lvl=0 → ret_err one-cycle pulse.
- Drop g_clr while in REQ → i_pending=0, nest_lvl=0, pc_out=0 immediately, without waiting for a clock edge. With MHVPIS_EDGE_EN and edge_sel[2]=1, holding itr_in[2] high → exactly one service.
